scrambler_frame_ctrl: RTL



---
 rtl/scrambler_ctrl_pkg.sv | 24 ++
 rtl/scrambler_lfsr_core.sv | 34 +++
 rtl/scrambler_frame_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/scrambler_ctrl_pkg.sv
// Shared types and helpers for the frame-level additive scrambler controller.
package scrambler_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      OUT   = 2'd2
   } state_t;

   localparam int FRAME_CNT_W = 16;
   localparam int LFSR_MAX_W  = 32;

   // Width-generic single step; callers zero-extend into LFSR_MAX_W and truncate the result.
   function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
      input logic [LFSR_MAX_W-1:0] state,
      input logic [LFSR_MAX_W-1:0] poly,
      input int unsigned           width
   );
      logic fb;
      fb = (^(state & poly)) ^ state[0];
      return (state >> 1) | (LFSR_MAX_W'(fb) << (width - 1));
   endfunction

endpackage

// File: rtl/scrambler_lfsr_core.sv
// Loadable bit-serial additive LFSR; load has priority over step.
module scrambler_lfsr_core
   import scrambler_ctrl_pkg::*;
#(
   parameter int                    LFSR_WIDTH   = 8,
   parameter logic [LFSR_WIDTH-1:0] POLYNOMIAL   = 8'h71,
   parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED = '1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [LFSR_WIDTH-1:0] load_val,
   input  logic                  step,
   input  logic                  d,
   output logic                  out_bit,
   output logic [LFSR_WIDTH-1:0] state
);

   logic [LFSR_WIDTH-1:0] r_lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= DEFAULT_SEED;
      end else if (load) begin
         r_lfsr <= load_val;
      end else if (step) begin
         r_lfsr <= LFSR_WIDTH'(lfsr_step(LFSR_MAX_W'(r_lfsr), LFSR_MAX_W'(POLYNOMIAL), LFSR_WIDTH));
      end
   end

   assign out_bit = d ^ r_lfsr[0];
   assign state   = r_lfsr;

endmodule

// File: rtl/scrambler_frame_ctrl.sv
// Frame sequencer: reseeds per frame, passes header/bypass words, serially scrambles payload.
module scrambler_frame_ctrl
   import scrambler_ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    LFSR_WIDTH   = 8,
   parameter logic [LFSR_WIDTH-1:0] POLYNOMIAL   = 8'h71,
   parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED = {LFSR_WIDTH{1'b1}},
   parameter int                    HDR_WORDS    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LFSR_WIDTH-1:0]  cfg_seed,
   input  logic                   cfg_bypass,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [DATA_WIDTH-1:0]  s_data,
   input  logic                   s_last,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic                   m_last,
   output logic                   busy,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic [LFSR_WIDTH-1:0]  lfsr_state
);

   // word_idx must still distinguish "frame start" from "inside frame" when HDR_WORDS is 0.
   localparam int IDX_MAX = (HDR_WORDS > 0) ? HDR_WORDS : 1;
   localparam int IDX_W   = $clog2(IDX_MAX + 1);
   localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [IDX_W-1:0] IDX_LIM  = IDX_W'(IDX_MAX);
   localparam logic [IDX_W-1:0] HDR_IDX  = IDX_W'(HDR_WORDS);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [DATA_WIDTH-1:0]    r_data;
   logic                     r_last;
   logic                     r_bypass;
   logic [IDX_W-1:0]         r_word_idx;
   logic [BIT_W-1:0]         r_bit_cnt;
   logic [FRAME_CNT_W-1:0]   r_frame_cnt;

   logic                     w_accept;
   logic                     w_frame_start;
   logic                     w_bypass;
   logic                     w_hdr;
   logic                     w_pass;
   logic                     w_last_bit;
   logic                     w_lfsr_load;
   logic [LFSR_WIDTH-1:0]    w_load_val;
   logic                     w_lfsr_step;
   logic                     w_d;
   logic                     w_out_bit;
   logic [LFSR_WIDTH-1:0]    w_lfsr;

   assign s_ready       = (r_state == IDLE) & ~rst;
   assign w_accept      = s_valid & s_ready;
   assign w_frame_start = (r_word_idx == '0);
   // On the first word the live cfg_bypass decides; bypass_q only covers later words.
   assign w_bypass      = w_frame_start ? cfg_bypass : r_bypass;
   assign w_pass        = w_hdr | w_bypass;
   assign w_last_bit    = (r_bit_cnt == BIT_LAST);

   generate
      if (HDR_WORDS > 0) begin : g_hdr
         assign w_hdr = (r_word_idx < HDR_IDX);
      end else begin : g_no_hdr
         assign w_hdr = 1'b0;
      end
   endgenerate

   assign w_lfsr_load = w_accept & w_frame_start;
   assign w_load_val  = (cfg_seed == '0) ? DEFAULT_SEED : cfg_seed;
   assign w_lfsr_step = (r_state == SHIFT);
   assign w_d         = r_data[r_bit_cnt];

   scrambler_lfsr_core #(
      .LFSR_WIDTH   (LFSR_WIDTH),
      .POLYNOMIAL   (POLYNOMIAL),
      .DEFAULT_SEED (DEFAULT_SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .load     (w_lfsr_load),
      .load_val (w_load_val),
      .step     (w_lfsr_step),
      .d        (w_d),
      .out_bit  (w_out_bit),
      .state    (w_lfsr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_pass ? OUT : SHIFT;
            end
         end
         SHIFT: begin
            if (w_last_bit) begin
               w_state_nxt = OUT;
            end
         end
         OUT: begin
            if (m_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data      <= '0;
         r_last      <= 1'b0;
         r_bypass    <= 1'b0;
         r_word_idx  <= '0;
         r_bit_cnt   <= '0;
         r_frame_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_data    <= s_data;
                  r_last    <= s_last;
                  r_bit_cnt <= '0;
                  if (w_frame_start) begin
                     r_bypass <= cfg_bypass;
                  end
                  if (r_word_idx != IDX_LIM) begin
                     r_word_idx <= r_word_idx + 1'b1;
                  end
               end
            end
            SHIFT: begin
               r_data[r_bit_cnt] <= w_out_bit;
               r_bit_cnt         <= r_bit_cnt + 1'b1;
            end
            OUT: begin
               if (m_ready && r_last) begin
                  r_word_idx  <= '0;
                  r_frame_cnt <= r_frame_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign m_valid    = (r_state == OUT);
   assign m_data     = r_data;
   assign m_last     = r_last;
   assign busy       = (r_state != IDLE);
   assign frame_cnt  = r_frame_cnt;
   assign lfsr_state = w_lfsr;

endmodule
